// File: rtl/preset_flash_writer.sv
// preset_flash_writer
//   Keeps a shadow copy of up to BUTTONS_CNT 32-bit preset records and commits
//   dirty records to SPI flash over a Wishbone-style single-word write master.
//   A record update arms a settle timer; when it expires (or on flush) every
//   dirty record is written in ascending index order, one word per record.
//   Retry responses back off and reissue the same word up to RETRY_MAX times.
//
// Ports
//   clk, rst_i                  clock, asynchronous active-high reset
//   rec_we, rec_idx, rec_data   record update strobe, 1-based index, contents
//   flush                       commit now, skipping the settle delay
//   spi_adr_o, spi_dat_o        address / data of the current write cycle
//   spi_we_o, spi_stb_o         write enable and cycle strobe
//   spi_ack_i/rty_i/err_i       cycle termination: success / retry / fatal
//   busy, done, err, dirty      status: not idle, pass complete, sticky error,
//                               per-record pending bits (bit i-1 = record i)
module preset_flash_writer #(
  parameter int          BUTTONS_CNT = 4,
  parameter logic [23:0] BASE_ADDR   = 24'h000000,
  parameter int          SETTLE_CNT  = 1_000_000,
  parameter int          BACKOFF_CNT = 64,
  parameter int          RETRY_MAX   = 3
) (
  input  logic                   clk,
  input  logic                   rst_i,
  input  logic                   rec_we,
  input  logic [1:0]             rec_idx,
  input  logic [31:0]            rec_data,
  input  logic                   flush,
  output logic [23:0]            spi_adr_o,
  output logic [31:0]            spi_dat_o,
  output logic                   spi_we_o,
  output logic                   spi_stb_o,
  input  logic                   spi_ack_i,
  input  logic                   spi_rty_i,
  input  logic                   spi_err_i,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [BUTTONS_CNT-1:0] dirty
);

  localparam int IDX_W = (BUTTONS_CNT > 1) ? $clog2(BUTTONS_CNT) : 1;
  localparam int SET_W = $clog2(SETTLE_CNT + 1);
  localparam int BOF_W = $clog2(BACKOFF_CNT + 1);
  localparam int RTY_W = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;

  localparam logic [SET_W-1:0] SETTLE_LAST  = SET_W'(SETTLE_CNT - 1);
  localparam logic [BOF_W-1:0] BACKOFF_LAST = BOF_W'(BACKOFF_CNT - 1);
  localparam logic [RTY_W-1:0] RETRY_LAST   = RTY_W'(RETRY_MAX);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_SELECT  = 3'd2,
    ST_WRITE   = 3'd3,
    ST_BACKOFF = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [SET_W-1:0]       settle_q, settle_d;
  logic [BOF_W-1:0]       backoff_q, backoff_d;
  logic [RTY_W-1:0]       retry_q, retry_d;
  logic [IDX_W-1:0]       cur_q, cur_d;
  logic [23:0]            adr_q, adr_d;
  logic [31:0]            dat_q, dat_d;
  logic                   stb_q, stb_d;
  logic                   we_q, we_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
  logic [BUTTONS_CNT-1:0] dirty_q, dirty_d;
  logic [31:0]            shadow_q [BUTTONS_CNT];
  logic [31:0]            shadow_d [BUTTONS_CNT];

  logic                   we_ok_s;
  logic                   any_dirty_s;
  logic                   flush_ok_s;
  logic                   term_s;
  logic                   err_hit_s;
  logic                   rty_hit_s;
  logic                   ack_hit_s;
  logic [IDX_W-1:0]       pick_idx_s;

  // Qualify inputs and rank the slave's termination signals (err > rty > ack).
  always_comb begin
    we_ok_s     = rec_we && (rec_idx != 2'd0) && (int'(rec_idx) <= BUTTONS_CNT);
    any_dirty_s = |dirty_q;
    // An accepted flush also clears the sticky error; it only counts when it
    // actually starts a commit.
    flush_ok_s  = flush && (((state_q == ST_IDLE) && (any_dirty_s || we_ok_s)) ||
                            (state_q == ST_SETTLE));
    // Terminations are only meaningful while the strobe is actually out.
    term_s      = (state_q == ST_WRITE) && stb_q;
    err_hit_s   = term_s && spi_err_i;
    rty_hit_s   = term_s && !spi_err_i && spi_rty_i;
    ack_hit_s   = term_s && !spi_err_i && !spi_rty_i && spi_ack_i;
  end

  // Priority pick of the lowest-index dirty record.
  always_comb begin
    pick_idx_s = '0;
    for (int i = BUTTONS_CNT - 1; i >= 0; i--) begin
      pick_idx_s = dirty_q[i] ? IDX_W'(i) : pick_idx_s;
    end
  end

  // Shadow and dirty next-state: a new record write always wins over the
  // ack-clear, so data arriving in the ack cycle gets written again.
  always_comb begin
    for (int i = 0; i < BUTTONS_CNT; i++) begin
      shadow_d[i] = shadow_q[i];
      dirty_d[i]  = dirty_q[i];
      if (we_ok_s && (int'(rec_idx) == i + 1)) begin
        shadow_d[i] = rec_data;
        dirty_d[i]  = 1'b1;
      end else if (ack_hit_s && (int'(cur_q) == i)) begin
        dirty_d[i]  = 1'b0;
      end else begin
        dirty_d[i]  = dirty_q[i];
      end
    end
  end

  // Commit FSM next-state and registered bus/status outputs.
  always_comb begin
    state_d   = state_q;
    settle_d  = settle_q;
    backoff_d = backoff_q;
    retry_d   = retry_q;
    cur_d     = cur_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    stb_d     = 1'b0;
    done_d    = 1'b0;
    err_d     = err_q;

    case (state_q)
      ST_IDLE: begin
        if (flush_ok_s) begin
          state_d = ST_SELECT;
          err_d   = 1'b0;
        end else if (we_ok_s) begin
          state_d  = ST_SETTLE;
          settle_d = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_SETTLE: begin
        if (flush_ok_s) begin
          state_d  = ST_SELECT;
          settle_d = '0;
          err_d    = 1'b0;
        end else if (we_ok_s) begin
          settle_d = '0;
        end else if (settle_q == SETTLE_LAST) begin
          state_d  = ST_SELECT;
          settle_d = '0;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end

      // Latch the word here so later record updates cannot disturb the
      // cycle in flight; the strobe rises one cycle after entering WRITE.
      ST_SELECT: begin
        if (any_dirty_s) begin
          cur_d   = pick_idx_s;
          adr_d   = BASE_ADDR + (24'(pick_idx_s) << 2);
          dat_d   = shadow_q[pick_idx_s];
          retry_d = '0;
          state_d = ST_WRITE;
        end else begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end

      ST_WRITE: begin
        if (err_hit_s) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else if (rty_hit_s) begin
          if (retry_q == RETRY_LAST) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            retry_d   = retry_q + 1'b1;
            backoff_d = '0;
            state_d   = ST_BACKOFF;
          end
        end else if (ack_hit_s) begin
          state_d = ST_SELECT;
        end else begin
          stb_d = 1'b1;
        end
      end

      // Reissue straight into an active strobe so the gap is exactly
      // BACKOFF_CNT cycles.
      ST_BACKOFF: begin
        if (backoff_q == BACKOFF_LAST) begin
          backoff_d = '0;
          stb_d     = 1'b1;
          state_d   = ST_WRITE;
        end else begin
          backoff_d = backoff_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    we_d   = stb_d;
    busy_d = (state_d != ST_IDLE);
  end

  // State, counters, shadow records and registered outputs.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      settle_q  <= '0;
      backoff_q <= '0;
      retry_q   <= '0;
      cur_q     <= '0;
      adr_q     <= 24'h000000;
      dat_q     <= 32'h00000000;
      stb_q     <= 1'b0;
      we_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      dirty_q   <= '0;
      for (int i = 0; i < BUTTONS_CNT; i++) begin
        shadow_q[i] <= 32'h00000000;
      end
    end else begin
      state_q   <= state_d;
      settle_q  <= settle_d;
      backoff_q <= backoff_d;
      retry_q   <= retry_d;
      cur_q     <= cur_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      stb_q     <= stb_d;
      we_q      <= we_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      dirty_q   <= dirty_d;
      for (int i = 0; i < BUTTONS_CNT; i++) begin
        shadow_q[i] <= shadow_d[i];
      end
    end
  end

  assign spi_adr_o = adr_q;
  assign spi_dat_o = dat_q;
  assign spi_stb_o = stb_q;
  assign spi_we_o  = we_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign dirty     = dirty_q;

endmodule

// File: tb/tb_preset_flash_writer.sv
// Directed bench for preset_flash_writer with short settle/backoff timers.
module tb_preset_flash_writer;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        rec_we;
  logic [1:0]  rec_idx;
  logic [31:0] rec_data;
  logic        flush;
  logic [23:0] spi_adr_o;
  logic [31:0] spi_dat_o;
  logic        spi_we_o;
  logic        spi_stb_o;
  logic        spi_ack_i;
  logic        spi_rty_i;
  logic        spi_err_i;
  logic        busy;
  logic        done;
  logic        err;
  logic [3:0]  dirty;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int stb_starts = 0;
  logic stb_prev = 1'b0;

  preset_flash_writer #(
    .BUTTONS_CNT(4), .BASE_ADDR(24'h000000), .SETTLE_CNT(16),
    .BACKOFF_CNT(4), .RETRY_MAX(3)
  ) dut (
    .clk(clk), .rst_i(rst_i), .rec_we(rec_we), .rec_idx(rec_idx),
    .rec_data(rec_data), .flush(flush), .spi_adr_o(spi_adr_o),
    .spi_dat_o(spi_dat_o), .spi_we_o(spi_we_o), .spi_stb_o(spi_stb_o),
    .spi_ack_i(spi_ack_i), .spi_rty_i(spi_rty_i), .spi_err_i(spi_err_i),
    .busy(busy), .done(done), .err(err), .dirty(dirty)
  );

  always #5 clk = ~clk;

  // Count done pulses and strobe rising edges seen by the bus.
  always @(posedge clk) begin
    if (done === 1'b1) done_cnt <= done_cnt + 1;
    if (spi_stb_o === 1'b1 && stb_prev !== 1'b1) stb_starts <= stb_starts + 1;
    stb_prev <= spi_stb_o;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Steps until the strobe is seen; n = steps taken, -1 on timeout.
  task automatic wait_stb(input int max_steps, output int n);
    n = -1;
    for (int k = 1; k <= max_steps; k++) begin
      step();
      if (spi_stb_o === 1'b1) begin
        n = k;
        break;
      end
    end
  endtask

  task automatic do_reset();
    rst_i = 1'b1; rec_we = 1'b0; rec_idx = 2'd0; rec_data = 32'h0;
    flush = 1'b0; spi_ack_i = 1'b0; spi_rty_i = 1'b0; spi_err_i = 1'b0;
    step(); step();
    rst_i = 1'b0;
    step();
  endtask

  task automatic write_rec(input logic [1:0] idx, input logic [31:0] data);
    rec_we = 1'b1; rec_idx = idx; rec_data = data;
    step();
    rec_we = 1'b0; rec_idx = 2'd0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; rec_we = 1'b0; rec_idx = 2'd0; rec_data = 32'h0;
    flush = 1'b0; spi_ack_i = 1'b0; spi_rty_i = 1'b0; spi_err_i = 1'b0;
    #2;
    checks++; if ({spi_stb_o, spi_we_o, busy, done, err} !== 5'b00000) begin errors++; $display("FAIL reset_flags: got %b want 00000", {spi_stb_o, spi_we_o, busy, done, err}); end
    checks++; if ({spi_adr_o, spi_dat_o} !== 56'h0) begin errors++; $display("FAIL reset_bus: got %h/%h want 0/0", spi_adr_o, spi_dat_o); end
    checks++; if (dirty !== 4'b0000) begin errors++; $display("FAIL reset_dirty: got %b want 0000", dirty); end
    step(); step();
    rst_i = 1'b0;
    step();
  endtask

  task automatic test_ignore();
    int d0;
    d0 = done_cnt;
    write_rec(2'd0, 32'hDEADBEEF);
    checks++; if ({busy, dirty} !== 5'b00000) begin errors++; $display("FAIL idx0_ignored: got busy/dirty %b want 00000", {busy, dirty}); end
    do_flush();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL empty_flush_busy: got %b want 0", busy); end
    step(); step();
    checks++; if (done_cnt !== d0) begin errors++; $display("FAIL empty_flush_done: got %0d pulses want 0", done_cnt - d0); end
  endtask

  task automatic test_settle_write();
    int n, d0;
    do_reset();
    d0 = done_cnt;
    write_rec(2'd2, 32'hB02E7F1E);
    checks++; if ({busy, dirty} !== 5'b10010) begin errors++; $display("FAIL settle_start: got busy/dirty %b want 10010", {busy, dirty}); end
    wait_stb(40, n);
    checks++; if (n !== 18) begin errors++; $display("FAIL settle_latency: got %0d want 18", n); end
    checks++; if ({spi_adr_o, spi_dat_o, spi_we_o} !== {24'h000004, 32'hB02E7F1E, 1'b1}) begin errors++; $display("FAIL settle_word: got %h %h %b want 000004 b02e7f1e 1", spi_adr_o, spi_dat_o, spi_we_o); end
    step(); step();
    checks++; if ({spi_stb_o, spi_adr_o, spi_dat_o} !== {1'b1, 24'h000004, 32'hB02E7F1E}) begin errors++; $display("FAIL settle_hold: got %b %h %h want 1 000004 b02e7f1e", spi_stb_o, spi_adr_o, spi_dat_o); end
    spi_ack_i = 1'b1; step(); spi_ack_i = 1'b0;
    checks++; if ({spi_stb_o, dirty} !== 5'b00000) begin errors++; $display("FAIL settle_ack: got stb/dirty %b want 00000", {spi_stb_o, dirty}); end
    step();
    checks++; if ({done, busy} !== 2'b10) begin errors++; $display("FAIL settle_done: got done/busy %b want 10", {done, busy}); end
    step();
    checks++; if (done_cnt !== d0 + 1) begin errors++; $display("FAIL settle_done_count: got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_flush_order();
    int n, d0;
    do_reset();
    d0 = done_cnt;
    write_rec(2'd3, 32'h33333333);
    write_rec(2'd1, 32'h11111111);
    checks++; if (dirty !== 4'b0101) begin errors++; $display("FAIL order_dirty: got %b want 0101", dirty); end
    do_flush();
    wait_stb(10, n);
    checks++; if ({n, spi_adr_o, spi_dat_o} !== {32'd2, 24'h000000, 32'h11111111}) begin errors++; $display("FAIL order_first: got %0d %h %h want 2 000000 11111111", n, spi_adr_o, spi_dat_o); end
    spi_ack_i = 1'b1; step(); spi_ack_i = 1'b0;
    checks++; if ({dirty, done} !== 5'b01000) begin errors++; $display("FAIL order_mid: got dirty/done %b want 01000", {dirty, done}); end
    wait_stb(10, n);
    checks++; if ({n, spi_adr_o, spi_dat_o} !== {32'd2, 24'h000008, 32'h33333333}) begin errors++; $display("FAIL order_second: got %0d %h %h want 2 000008 33333333", n, spi_adr_o, spi_dat_o); end
    spi_ack_i = 1'b1; step(); spi_ack_i = 1'b0;
    step();
    checks++; if ({done, dirty} !== 5'b10000) begin errors++; $display("FAIL order_done: got done/dirty %b want 10000", {done, dirty}); end
    step();
    checks++; if (done_cnt !== d0 + 1) begin errors++; $display("FAIL order_done_count: got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_retry();
    int n, d0, s0;
    do_reset();
    d0 = done_cnt;
    s0 = stb_starts;
    write_rec(2'd1, 32'hCAFEF00D);
    do_flush();
    wait_stb(10, n);
    checks++; if (n !== 2) begin errors++; $display("FAIL retry_first: got %0d want 2", n); end
    for (int r = 0; r < 3; r++) begin
      spi_rty_i = 1'b1; step(); spi_rty_i = 1'b0;
      checks++; if ({spi_stb_o, busy} !== 2'b01) begin errors++; $display("FAIL retry_drop%0d: got stb/busy %b want 01", r, {spi_stb_o, busy}); end
      wait_stb(10, n);
      checks++; if ({n, spi_adr_o, spi_dat_o} !== {32'd4, 24'h000000, 32'hCAFEF00D}) begin errors++; $display("FAIL retry_reissue%0d: got %0d %h %h want 4 000000 cafef00d", r, n, spi_adr_o, spi_dat_o); end
    end
    spi_rty_i = 1'b1; step(); spi_rty_i = 1'b0;
    checks++; if ({err, busy, spi_stb_o, dirty} !== 7'b1000001) begin errors++; $display("FAIL retry_exhaust: got err/busy/stb/dirty %b want 1000001", {err, busy, spi_stb_o, dirty}); end
    for (int k = 0; k < 10; k++) step();
    checks++; if (stb_starts - s0 !== 4) begin errors++; $display("FAIL retry_strobes: got %0d want 4", stb_starts - s0); end
    checks++; if (done_cnt !== d0) begin errors++; $display("FAIL retry_no_done: got %0d pulses want 0", done_cnt - d0); end
  endtask

  task automatic test_rewrite();
    int n, d0;
    do_reset();
    d0 = done_cnt;
    write_rec(2'd1, 32'hAAAA0001);
    do_flush();
    wait_stb(10, n);
    checks++; if ({n, spi_dat_o} !== {32'd2, 32'hAAAA0001}) begin errors++; $display("FAIL rewrite_first: got %0d %h want 2 aaaa0001", n, spi_dat_o); end
    write_rec(2'd1, 32'hCCCC0003);
    checks++; if ({spi_stb_o, spi_dat_o} !== {1'b1, 32'hAAAA0001}) begin errors++; $display("FAIL rewrite_latched: got %b %h want 1 aaaa0001", spi_stb_o, spi_dat_o); end
    spi_ack_i = 1'b1; rec_we = 1'b1; rec_idx = 2'd1; rec_data = 32'hBBBB0002;
    step();
    spi_ack_i = 1'b0; rec_we = 1'b0; rec_idx = 2'd0;
    checks++; if ({dirty, done} !== 5'b00010) begin errors++; $display("FAIL rewrite_dirty_kept: got dirty/done %b want 00010", {dirty, done}); end
    wait_stb(10, n);
    checks++; if ({n, spi_adr_o, spi_dat_o} !== {32'd2, 24'h000000, 32'hBBBB0002}) begin errors++; $display("FAIL rewrite_second: got %0d %h %h want 2 000000 bbbb0002", n, spi_adr_o, spi_dat_o); end
    spi_ack_i = 1'b1; step(); spi_ack_i = 1'b0;
    step();
    checks++; if ({done, dirty} !== 5'b10000) begin errors++; $display("FAIL rewrite_done: got done/dirty %b want 10000", {done, dirty}); end
    step();
    checks++; if (done_cnt !== d0 + 1) begin errors++; $display("FAIL rewrite_done_count: got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_err_priority();
    int n, d0;
    do_reset();
    d0 = done_cnt;
    write_rec(2'd2, 32'h12345678);
    do_flush();
    wait_stb(10, n);
    spi_err_i = 1'b1; spi_ack_i = 1'b1; step(); spi_err_i = 1'b0; spi_ack_i = 1'b0;
    checks++; if ({err, busy, spi_stb_o, dirty} !== 7'b1000010) begin errors++; $display("FAIL err_prio: got err/busy/stb/dirty %b want 1000010", {err, busy, spi_stb_o, dirty}); end
    step(); step();
    checks++; if ({err, done_cnt} !== {1'b1, d0}) begin errors++; $display("FAIL err_sticky: got err %b pulses %0d want 1 0", err, done_cnt - d0); end
    do_flush();
    checks++; if ({err, busy} !== 2'b01) begin errors++; $display("FAIL err_clear: got err/busy %b want 01", {err, busy}); end
    wait_stb(10, n);
    checks++; if ({n, spi_adr_o, spi_dat_o} !== {32'd2, 24'h000004, 32'h12345678}) begin errors++; $display("FAIL err_recommit: got %0d %h %h want 2 000004 12345678", n, spi_adr_o, spi_dat_o); end
    spi_ack_i = 1'b1; step(); spi_ack_i = 1'b0;
    step();
    checks++; if ({done, dirty, err} !== 6'b100000) begin errors++; $display("FAIL err_recommit_done: got done/dirty/err %b want 100000", {done, dirty, err}); end
  endtask

  task automatic test_reset_mid_write();
    int n, d0, s0;
    do_reset();
    write_rec(2'd3, 32'h0BADF00D);
    do_flush();
    wait_stb(10, n);
    checks++; if (n !== 2) begin errors++; $display("FAIL rst_mid_setup: got %0d want 2", n); end
    #2 rst_i = 1'b1;
    #1;
    checks++; if ({spi_stb_o, spi_we_o, busy, done, dirty} !== 8'h00) begin errors++; $display("FAIL rst_mid_async: got stb/we/busy/done/dirty %b want 00000000", {spi_stb_o, spi_we_o, busy, done, dirty}); end
    step();
    rst_i = 1'b0;
    step();
    d0 = done_cnt;
    s0 = stb_starts;
    for (int k = 0; k < 30; k++) step();
    checks++; if ({stb_starts - s0, done_cnt - d0, busy} !== {32'd0, 32'd0, 1'b0}) begin errors++; $display("FAIL rst_mid_quiet: got strobes %0d done %0d busy %b want 0 0 0", stb_starts - s0, done_cnt - d0, busy); end
  endtask

  initial begin
    test_reset();
    test_ignore();
    test_settle_write();
    test_flush_order();
    test_retry();
    test_rewrite();
    test_err_priority();
    test_reset_mid_write();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
